// File: rtl/burst_mem_model.sv
// burst_mem_model
//   Multi-cycle, line-wide memory model for the cached MIPS generation. Each
//   access takes LATENCY cycles and moves one BURST-word line through a
//   req/ready handshake with an I-cache or D-cache miss engine.
//   The array is never cleared by reset.
//   Optional feature macro: MEM_STATS_EN adds completed-access and busy-cycle counters.
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high (aborts any access in flight)
//   i_mem_read     read request, held until o_mem_ready
//   i_mem_write    write request, held until o_mem_ready
//   i_mem_addr     line address
//   i_mem_wdata    write line, word k at [k*DATA_W +: DATA_W]
//   o_mem_ready    one-cycle completion pulse
//   o_mem_rdata    read line, held until the next read completes
//   o_mem_err      one-cycle pulse when read and write are requested together
//   o_stat_rd_cnt  (MEM_STATS_EN) completed reads
//   o_stat_wr_cnt  (MEM_STATS_EN) completed writes
//   o_stat_busy_cyc(MEM_STATS_EN) cycles spent in BUSY
module burst_mem_model #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST     = 4,
   parameter int unsigned LATENCY   = 4,
   parameter string       INIT_FILE = "",
   localparam int unsigned LINE_W   = DATA_W * BURST
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [LINE_W-1:0] i_mem_wdata,
   output logic              o_mem_ready,
   output logic [LINE_W-1:0] o_mem_rdata,
   output logic              o_mem_err
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]       o_stat_rd_cnt,
   output logic [31:0]       o_stat_wr_cnt,
   output logic [31:0]       o_stat_busy_cyc
`endif
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_op_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic [LINE_W-1:0]   r_mem [DEPTH];

   logic                w_commit;

   // Last BUSY cycle: the access completes at this edge.
   assign w_commit = (r_state == BUSY) && (r_cnt == '0);

   // Array write port; no reset so contents survive rst, and a reset at the
   // commit edge drops the write.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_commit && r_op_wr) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         o_mem_ready <= 1'b0;
         o_mem_err   <= 1'b0;
         o_mem_rdata <= '0;
`ifdef MEM_STATS_EN
         o_stat_rd_cnt   <= '0;
         o_stat_wr_cnt   <= '0;
         o_stat_busy_cyc <= '0;
`endif
      end else begin
         o_mem_ready <= 1'b0;
         o_mem_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_mem_read && i_mem_write) begin
                  o_mem_err <= 1'b1;
               end else if (i_mem_read || i_mem_write) begin
                  r_op_wr <= i_mem_write;
                  r_addr  <= i_mem_addr;
                  r_wdata <= i_mem_wdata;
                  r_cnt   <= CNT_W'(LATENCY - 1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
`ifdef MEM_STATS_EN
               o_stat_busy_cyc <= o_stat_busy_cyc + 32'd1;
`endif
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  if (!r_op_wr) begin
                     o_mem_rdata <= r_mem[r_addr];
                  end
`ifdef MEM_STATS_EN
                  if (r_op_wr) begin
                     o_stat_wr_cnt <= o_stat_wr_cnt + 32'd1;
                  end else begin
                     o_stat_rd_cnt <= o_stat_rd_cnt + 32'd1;
                  end
`endif
                  o_mem_ready <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               // Inputs ignored; requester drops its request on ready.
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_mem_model.sv
// tb_burst_mem_model
//   Randomized bench for burst_mem_model with a reference array and an
//   expectation queue consumed by an independent output monitor.
module tb_burst_mem_model;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BURST  = 4;
   localparam int unsigned LAT    = 4;
   localparam int unsigned LINE_W = DATA_W * BURST;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   localparam logic [1:0] K_RD  = 2'd0;
   localparam logic [1:0] K_WR  = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]        kind;
      logic [LINE_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [LINE_W-1:0] mem_wdata = '0;
   logic              mem_ready;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_err;
`ifdef MEM_STATS_EN
   logic [31:0]       stat_rd_cnt;
   logic [31:0]       stat_wr_cnt;
   logic [31:0]       stat_busy_cyc;
`endif

   int total = 0;
   int bad   = 0;

   logic [LINE_W-1:0] ref_mem [DEPTH];
   logic [LINE_W-1:0] last_rd;
   exp_t              exp_q[$];

   always #5 clk = ~clk;

   burst_mem_model #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BURST  (BURST),
      .LATENCY(LAT)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_mem_read (mem_read),
      .i_mem_write(mem_write),
      .i_mem_addr (mem_addr),
      .i_mem_wdata(mem_wdata),
      .o_mem_ready(mem_ready),
      .o_mem_rdata(mem_rdata),
      .o_mem_err  (mem_err)
`ifdef MEM_STATS_EN
      ,
      .o_stat_rd_cnt  (stat_rd_cnt),
      .o_stat_wr_cnt  (stat_wr_cnt),
      .o_stat_busy_cyc(stat_busy_cyc)
`endif
   );

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [LINE_W-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: every ready or err pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_ready || mem_err) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: ready=%0b err=%0b with nothing outstanding",
                     mem_ready, mem_err);
         end else begin
            e = exp_q.pop_front();
            if (e.kind == K_ERR) begin
               check("err_pulse", {mem_err, mem_ready}, {1'b1, 1'b0});
            end else begin
               check("ready_pulse", {mem_err, mem_ready}, {1'b0, 1'b1});
               // Reads return the line; writes leave the previous read line held.
               check(e.kind == K_RD ? "rdata_read" : "rdata_hold_on_write",
                     mem_rdata, e.data);
            end
         end
      end
   end

   // One handshake; returns in the IDLE cycle after DONE.
   task automatic access(input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d);
      int  n;
      bit  seen;
      exp_t e;
      mem_read  = !wr;
      mem_write = wr;
      mem_addr  = a;
      mem_wdata = d;
      if (wr) begin
         ref_mem[a] = d;
         e.kind = K_WR;
         e.data = last_rd;
      end else begin
         last_rd = ref_mem[a];
         e.kind = K_RD;
         e.data = ref_mem[a];
      end
      exp_q.push_back(e);
      n = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (mem_ready) seen = 1;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      // Edges counted include the accept edge, so LAT more follow it.
      check("ready_latency", LINE_W'(seen ? n : 0), LINE_W'(LAT + 1));
      if (!seen) void'(exp_q.pop_front());
      @(posedge clk); #1;
   endtask

   task automatic conflict(input logic [ADDR_W-1:0] a);
      exp_t e;
      e.kind = K_ERR;
      e.data = '0;
      exp_q.push_back(e);
      mem_read  = 1'b1;
      mem_write = 1'b1;
      mem_addr  = a;
      mem_wdata = rnd_line();
      @(posedge clk); #1;
      check("err_registered", LINE_W'(mem_err), LINE_W'(1));
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk); #1;
      check("err_one_cycle", LINE_W'({mem_err, mem_ready}), LINE_W'(0));
   endtask

   task automatic pulse_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_ready_err", LINE_W'({mem_ready, mem_err}), LINE_W'(0));
      check("rst_rdata", mem_rdata, '0);
      rst = 1'b0;
      last_rd = '0;
   endtask

   // Write that is killed by reset on its second BUSY cycle.
   task automatic aborted_write(input logic [ADDR_W-1:0] a);
      mem_write = 1'b1;
      mem_addr  = a;
      mem_wdata = {LINE_W{1'b1}};
      @(posedge clk); #1;   // accepted, first BUSY cycle
      @(posedge clk); #1;   // second BUSY cycle
      mem_write = 1'b0;
      pulse_reset(1);
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      last_rd = '0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

      // Reset held for two cycles.
      pulse_reset(2);
`ifdef MEM_STATS_EN
      check("rst_stats", LINE_W'({stat_rd_cnt, stat_wr_cnt, stat_busy_cyc}), '0);
`endif

      // Give every line a known value.
      for (int i = 0; i < int'(DEPTH); i++) access(1'b1, ADDR_W'(i), rnd_line());

      // Write then read line 5.
      access(1'b1, 6'd5, 128'h0000000F_00000014_0000001E_00000028);
      access(1'b0, 6'd5, '0);
      check("line5_value", mem_rdata, 128'h0000000F_00000014_0000001E_00000028);

      // Back-to-back reads of lines 0 and 1, then the address extremes.
      access(1'b0, 6'd0, '0);
      access(1'b0, 6'd1, '0);
      access(1'b1, 6'd63, rnd_line());
      access(1'b0, 6'd63, '0);
      access(1'b0, 6'd0, '0);

      // Conflicting request on line 2 leaves it unchanged.
      conflict(6'd2);
      access(1'b0, 6'd2, '0);

      // Reset during a write to line 3; old contents must survive.
      aborted_write(6'd3);
      access(1'b0, 6'd3, '0);

      // Randomized traffic including read-after-write to the same line.
      for (int i = 0; i < 150; i++) begin
         int unsigned k;
         logic [ADDR_W-1:0] a;
         k = $urandom_range(0, 9);
         a = ADDR_W'($urandom_range(0, DEPTH - 1));
         if (k == 0) conflict(a);
         else if (k < 5) begin
            access(1'b1, a, rnd_line());
            if (k == 1) access(1'b0, a, '0);
         end else access(1'b0, a, '0);
      end

      // Statistics window: 3 reads and 2 writes after a fresh reset.
      pulse_reset(1);
      access(1'b0, 6'd7, '0);
      access(1'b1, 6'd8, rnd_line());
      access(1'b0, 6'd8, '0);
      access(1'b1, 6'd9, rnd_line());
      access(1'b0, 6'd63, '0);
`ifdef MEM_STATS_EN
      check("stat_rd_cnt", LINE_W'(stat_rd_cnt), LINE_W'(3));
      check("stat_wr_cnt", LINE_W'(stat_wr_cnt), LINE_W'(2));
      check("stat_busy_cyc", LINE_W'(stat_busy_cyc), LINE_W'(5 * LAT));
`endif

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", LINE_W'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
